pong_game_sequencer: RTL

Game-level controller for the pong datapath. Divides the system clock into game steps and issues one-cycle `step` and `serve` strobes to the ball/paddle datapath. Sequences the match through serve, play, point and game-over phases, keeps both scores, and reports the winner. Sits between the pin-level inputs and the datapath and owns every datapath advance and re-serve.

---
 rtl/pong_game_sequencer_if.sv | 25 ++
 rtl/pong_game_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pong_game_sequencer_if.sv
// Pin-level control and datapath strobe bundle for the pong game sequencer.
// master = sequencer side, slave = stimulus/datapath side.
interface pong_game_sequencer_if;
  logic       start;
  logic       pause;
  logic       miss_left;
  logic       miss_right;
  logic       step;
  logic       serve;
  logic       serve_dir;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic [2:0] state;
  logic       winner;

  modport master (
    input  start, pause, miss_left, miss_right,
    output step, serve, serve_dir, score_left, score_right, state, winner
  );

  modport slave (
    output start, pause, miss_left, miss_right,
    input  step, serve, serve_dir, score_left, score_right, state, winner
  );
endinterface

// File: rtl/pong_game_sequencer.sv
// Match controller for pong: divides clk into game ticks, sequences serve/play/point/
// game-over phases, keeps scores and issues one-cycle step/serve strobes to the datapath.
module pong_game_sequencer #(
  parameter logic [15:0] TICK_DIV    = 16'd50000,
  parameter logic [7:0]  SERVE_DELAY = 8'd60,
  parameter logic [7:0]  POINT_DELAY = 8'd30,
  parameter logic [3:0]  WIN_SCORE   = 4'd9
) (
  input logic                    clk,
  input logic                    rst,
  pong_game_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_PLAY      = 3'd2,
    S_POINT     = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_tick_cnt;
  logic [7:0]  r_dly;
  logic        r_start_q;
  logic        r_step;
  logic        r_serve;
  logic        r_serve_dir;
  logic [3:0]  r_score_left;
  logic [3:0]  r_score_right;
  logic        r_winner;

  logic        w_tick;
  logic        w_start_rise;
  logic [3:0]  w_score_left_inc;
  logic [3:0]  w_score_right_inc;

  assign w_tick            = (r_tick_cnt == 16'(TICK_DIV - 16'd1));
  assign w_start_rise      = bus.start & ~r_start_q;
  assign w_score_left_inc  = 4'(r_score_left + 4'd1);
  assign w_score_right_inc = 4'(r_score_right + 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_tick_cnt    <= 16'd0;
      r_dly         <= 8'd0;
      r_start_q     <= 1'b0;
      r_step        <= 1'b0;
      r_serve       <= 1'b0;
      r_serve_dir   <= 1'b0;
      r_score_left  <= 4'd0;
      r_score_right <= 4'd0;
      r_winner      <= 1'b0;
    end else begin
      r_step     <= 1'b0;
      r_serve    <= 1'b0;
      r_start_q  <= bus.start;
      // Free-running tick phase, never realigned by state changes
      r_tick_cnt <= w_tick ? 16'd0 : 16'(r_tick_cnt + 16'd1);

      case (r_state)
        S_IDLE, S_GAME_OVER: begin
          if (w_start_rise) begin
            r_score_left  <= 4'd0;
            r_score_right <= 4'd0;
            r_serve_dir   <= 1'b0;
            r_winner      <= 1'b0;
            r_dly         <= 8'd0;
            r_state       <= S_SERVE;
          end
        end
        S_SERVE: begin
          if (w_tick) begin
            if (r_dly == 8'(SERVE_DELAY - 8'd1)) begin
              r_serve <= 1'b1;
              r_dly   <= 8'd0;
              r_state <= S_PLAY;
            end else begin
              r_dly <= 8'(r_dly + 8'd1);
            end
          end
        end
        S_PLAY: begin
          // miss_left takes priority when both edges report a miss
          if (w_tick && !bus.pause) begin
            if (bus.miss_left) begin
              r_score_right <= w_score_right_inc;
              r_serve_dir   <= 1'b0;
              r_dly         <= 8'd0;
              if (w_score_right_inc == WIN_SCORE) begin
                r_winner <= 1'b1;
                r_state  <= S_GAME_OVER;
              end else begin
                r_state  <= S_POINT;
              end
            end else if (bus.miss_right) begin
              r_score_left <= w_score_left_inc;
              r_serve_dir  <= 1'b1;
              r_dly        <= 8'd0;
              if (w_score_left_inc == WIN_SCORE) begin
                r_winner <= 1'b0;
                r_state  <= S_GAME_OVER;
              end else begin
                r_state  <= S_POINT;
              end
            end else begin
              r_step <= 1'b1;
            end
          end
        end
        S_POINT: begin
          if (w_tick) begin
            if (r_dly == 8'(POINT_DELAY - 8'd1)) begin
              r_dly   <= 8'd0;
              r_state <= S_SERVE;
            end else begin
              r_dly <= 8'(r_dly + 8'd1);
            end
          end
        end
        default: begin
          r_dly   <= 8'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.step        = r_step;
  assign bus.serve       = r_serve;
  assign bus.serve_dir   = r_serve_dir;
  assign bus.score_left  = r_score_left;
  assign bus.score_right = r_score_right;
  assign bus.state       = 3'(r_state);
  assign bus.winner      = r_winner;

endmodule
